input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//  Conditions a raw asynchronous level (switch/button) before it reaches the d_latch stage.
//  Synchronises d_raw, filters bounce, and drives the latch: d_clean feeds latch d.
//  en_pulse feeds latch en, so the latch goes transparent for exactly one cycle per committed change.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive synced samples that must differ from d_clean before commit; legal 1..65535
//  CNT_W          16  counter width; must satisfy 2**CNT_W > STABLE_CYCLES
// PORTS
//  clk       in   1  single clock; all flops rise-edge
//  rst       in   1  asynchronous, active-high reset
//  d_raw     in   1  raw asynchronous input level
//  d_clean   out  1  debounced level -> d_latch.d
//  en_pulse  out  1  1-cycle strobe when d_clean changes -> d_latch.en
//  rise      out  1  1-cycle strobe on 0->1 commit (only with DBNC_EDGE_OUT_EN)
//  fall      out  1  1-cycle strobe on 1->0 commit (only with DBNC_EDGE_OUT_EN)
// BEHAVIOUR
//  Reset (async assert, sync-to-clk use after deassert): sync flops=0, state=STABLE_LO, cnt=0.
//  Reset values: d_clean=0, en_pulse=0, rise=0, fall=0. All outputs registered.
//  Sync: 2-flop chain d_raw->s1->s2; only s2 used downstream.
//  FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO (2-bit encoding).
//   STABLE_LO: s2=1 -> CHECK_HI, cnt=1; if STABLE_CYCLES==1 commit directly to STABLE_HI.
//   CHECK_HI:  s2=0 -> STABLE_LO, cnt=0 (bounce, no output change).
//              s2=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, d_clean<=1, cnt=0.
//              else cnt<=cnt+1.
//   STABLE_HI / CHECK_LO: mirror with polarity inverted.
//  Commit edge: d_clean and en_pulse update on the same edge; en_pulse=1 for one cycle only.
//  Latency: d_raw stable from sampling edge k -> d_clean flips at edge k+1+STABLE_CYCLES.
//  Example: default is edge k+5.
//  Any s2 glitch inside CHECK_* restarts filtering from zero; no partial credit.
//  Counter never wraps: it saturates by construction at STABLE_CYCLES-1.
//  Back-to-back commits: en_pulse spacing is >= STABLE_CYCLES cycles; never high 2 consecutive cycles
//  (except STABLE_CYCLES==1 with toggling input: one pulse per commit).
//  Reset mid-CHECK: pending change discarded. d_clean=0 immediately, even if d_raw is held 1.
//  A held 1 then re-qualifies after the full latency from the first post-reset edge.
// CONFIGURATION
//  DBNC_EDGE_OUT_EN defined: rise/fall ports present and registered.
//   rise = en_pulse & new d_clean==1; fall = en_pulse & new d_clean==0.
//  DBNC_EDGE_OUT_EN undefined: rise/fall ports and their flops omitted; other behaviour identical.
// STRUCTURE
//  debounce_defs.vh (shared include): state localparams ST_STABLE_LO=2'd0, ST_CHECK_HI=2'd1,
//  ST_STABLE_HI=2'd2, ST_CHECK_LO=2'd3; default STABLE_CYCLES.
//  Sub-module sync_2ff (clk, rst, d, q): 2-flop synchroniser, reset to 0, reusable.
//  Top holds FSM, counter, output registers.
// TESTING
//  Bench instantiates input_debouncer -> d_latch chain, 10-time-unit clock, dumps VCD, $monitor on all ports.
//  1 Reset: rst=1 with d_raw=1 for 3 cycles -> d_clean=0, en_pulse=0, rise=fall=0 throughout.
//  2 Clean rise: d_raw 0->1 before edge k, held -> d_clean=1 at edge k+5.
//    en_pulse=1 for exactly cycle k+5..k+6; rise=1 same cycle; latch q=1 after.
//  3 Bounce: d_raw 1,0,1,0 toggling each cycle for 6 cycles, then 0 -> d_clean never leaves its value,
//    en_pulse stays 0.
//  4 Glitch mid-check: d_raw=1 for 3 cycles, 0 for 1, then 1 held -> commit 5 edges after the final 0->1 sample.
//  5 Fall: from d_clean=1, d_raw->0 held -> d_clean=0 at k+5, fall pulse 1 cycle; latch holds 0 afterwards.
//  6 Reset mid-operation: assert rst during CHECK_HI (cnt=2) -> outputs 0 async.
//    After deassert with d_raw=1, commit after full 5-edge latency; STABLE_CYCLES=1 rerun -> commit at k+2.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and parameter defaults.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CHECK_HI  = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CHECK_LO  = 2'd3
  } dbnc_state_e;

  localparam int unsigned DBNC_STABLE_CYCLES_DEF = 4;
  localparam int unsigned DBNC_CNT_W_DEF         = 16;

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both stages reset to 0.
module sync_2ff
  import input_debouncer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw switch level and drives a downstream latch (d_clean -> d, en_pulse -> en).
// Optional registered rise/fall strobes are built when DBNC_EDGE_OUT_EN is defined.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DBNC_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = DBNC_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic d_clean,
  output logic en_pulse
`ifdef DBNC_EDGE_OUT_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 ||
      (64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_param_check
    $error("input_debouncer: illegal STABLE_CYCLES/CNT_W combination");
  end

  logic             s2;
  dbnc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_clean_q, d_clean_d;
  logic             en_pulse_q, en_pulse_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d_raw),
    .q   (s2)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_clean_d  = d_clean_q;
    en_pulse_d = 1'b0;
    unique case (state_q)
      ST_STABLE_LO: begin
        if (s2) begin
          if (SINGLE) begin
            state_d    = ST_STABLE_HI;
            d_clean_d  = 1'b1;
            en_pulse_d = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = ST_CHECK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_CHECK_HI: begin
        // Any opposite sample throws away the partial count.
        if (!s2) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_STABLE_HI;
          d_clean_d  = 1'b1;
          en_pulse_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!s2) begin
          if (SINGLE) begin
            state_d    = ST_STABLE_LO;
            d_clean_d  = 1'b0;
            en_pulse_d = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = ST_CHECK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_CHECK_LO: begin
        if (s2) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_STABLE_LO;
          d_clean_d  = 1'b0;
          en_pulse_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STABLE_LO;
      cnt_q      <= '0;
      d_clean_q  <= 1'b0;
      en_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_clean_q  <= d_clean_d;
      en_pulse_q <= en_pulse_d;
    end
  end

  assign d_clean  = d_clean_q;
  assign en_pulse = en_pulse_q;

`ifdef DBNC_EDGE_OUT_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Direction is taken from the value being committed, so strobes align with en_pulse.
  always_comb begin
    rise_d = en_pulse_d & d_clean_d;
    fall_d = en_pulse_d & ~d_clean_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Checks two debouncers (STABLE_CYCLES=4 and =1) against a sample-history model, plus directed literals.
module tb_input_debouncer;

  localparam int N0 = 4;
  localparam int N1 = 1;

  logic clk = 1'b0;
  logic rst;
  logic d_raw;
  logic clean0, en0, clean1, en1;
`ifdef DBNC_EDGE_OUT_EN
  logic rise0, fall0, rise1, fall1;
`endif

  int checks = 0;
  int errors = 0;

  input_debouncer #(.STABLE_CYCLES(N0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .d_raw(d_raw), .d_clean(clean0), .en_pulse(en0)
`ifdef DBNC_EDGE_OUT_EN
    , .rise(rise0), .fall(fall0)
`endif
  );

  input_debouncer #(.STABLE_CYCLES(N1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .d_raw(d_raw), .d_clean(clean1), .en_pulse(en1)
`ifdef DBNC_EDGE_OUT_EN
    , .rise(rise1), .fall(fall1)
`endif
  );

  always #5 clk = ~clk;

  // Downstream latch fed by the 4-cycle debouncer.
  logic latch_q = 1'b0;
  always @(en0 or clean0) if (en0) latch_q = clean0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the filter sees each raw sample two edges late, and commits when the
  // last N seen samples all disagree with the current clean level.
  logic hist[$];
  logic r1 = 1'b0, r2 = 1'b0;
  logic m_clean[2] = '{1'b0, 1'b0};
  logic m_en[2]    = '{1'b0, 1'b0};

  function automatic bit run_differs(input int n, input logic c);
    if (hist.size() < n) return 1'b0;
    for (int k = 0; k < n; k++)
      if (hist[hist.size() - 1 - k] == c) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      r1 = 1'b0; r2 = 1'b0;
      hist.delete();
      for (int i = 0; i < 2; i++) begin
        m_clean[i] = 1'b0;
        m_en[i]    = 1'b0;
      end
    end else begin
      hist.push_back(r2);
      if (hist.size() > 16) void'(hist.pop_front());
      r2 = r1;
      r1 = d_raw;
      for (int i = 0; i < 2; i++) begin
        m_en[i] = 1'b0;
        if (run_differs((i == 0) ? N0 : N1, m_clean[i])) begin
          m_clean[i] = ~m_clean[i];
          m_en[i]    = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("clean4", clean0, m_clean[0]);
    chk("en4",    en0,    m_en[0]);
    chk("clean1", clean1, m_clean[1]);
    chk("en1",    en1,    m_en[1]);
`ifdef DBNC_EDGE_OUT_EN
    chk("rise4", rise0, m_en[0] & m_clean[0]);
    chk("fall4", fall0, m_en[0] & ~m_clean[0]);
    chk("rise1", rise1, m_en[1] & m_clean[1]);
    chk("fall1", fall1, m_en[1] & ~m_clean[1]);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    d_raw = 1'b1;
    // Reset held with input high: everything stays low.
    repeat (3) begin
      tick();
      chk("rst_clean4", clean0, 1'b0);
      chk("rst_en4", en0, 1'b0);
    end
    rst = 1'b0;
    tick();                                  // edge k
    tick(); chk("lat1_k1", clean1, 1'b0);
    tick(); chk("lat1_k2", clean1, 1'b1); chk("lat1_en", en1, 1'b1);
    tick(); chk("lat1_en_off", en1, 1'b0);
    tick(); chk("rise_k4", clean0, 1'b0);
    tick(); chk("rise_k5", clean0, 1'b1); chk("rise_en", en0, 1'b1);
`ifdef DBNC_EDGE_OUT_EN
    chk("rise_strobe", rise0, 1'b1);
`endif
    tick(); chk("rise_en_off", en0, 1'b0); chk("latch_hi", latch_q, 1'b1);

    // Clean fall.
    d_raw = 1'b0;
    repeat (5) tick();
    chk("fall_k4", clean0, 1'b1);
    tick(); chk("fall_k5", clean0, 1'b0); chk("fall_en", en0, 1'b1);
`ifdef DBNC_EDGE_OUT_EN
    chk("fall_strobe", fall0, 1'b1);
`endif
    tick(); chk("fall_en_off", en0, 1'b0); chk("latch_lo", latch_q, 1'b0);

    // Bounce: alternating samples never qualify.
    for (int i = 0; i < 6; i++) begin
      d_raw = (i % 2 == 0);
      tick();
      chk("bounce_en", en0, 1'b0);
    end
    d_raw = 1'b0;
    repeat (8) tick();
    chk("bounce_clean", clean0, 1'b0);

    // Glitch mid-check: 1,1,1,0 then 1 held -> commit 5 edges after the last rise.
    d_raw = 1'b1;
    repeat (3) tick();
    d_raw = 1'b0;
    tick();
    d_raw = 1'b1;
    repeat (5) tick();
    chk("glitch_k8", clean0, 1'b0);
    tick(); chk("glitch_k9", clean0, 1'b1);

    // Fall back to 0, then reset in CHECK_HI with cnt=2.
    d_raw = 1'b0;
    repeat (10) tick();
    d_raw = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_clean4", clean0, 1'b0);
    chk("async_clean1", clean1, 1'b0);
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("requal_k4", clean0, 1'b0);
    tick(); chk("requal_k5", clean0, 1'b1);

    // Random levels with random hold times and occasional resets.
    for (int i = 0; i < 500; i++) begin
      d_raw = ($urandom_range(0, 1) != 0);
      repeat ($urandom_range(1, 9)) tick();
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
